// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG_W-bit segment per stage, operands skewed in, sums deskewed out.
// Optional signed saturation of the final result when PIPE_ADDER_SAT_EN is defined.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NSTG = WIDTH / SEG_W;

    if (SEG_W < 1 || WIDTH % SEG_W != 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH (%0d) must be a positive multiple of SEG_W (%0d)", WIDTH, SEG_W);
    end

    function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] a,
                                                input logic [SEG_W-1:0] b,
                                                input logic             ci);
        logic             c;
        logic [SEG_W-1:0] s;
        logic [1:0]       f;
        c = ci;
        s = '0;
        for (int i = 0; i < SEG_W; i++) begin
            f    = fa(a[i], b[i], c);
            s[i] = f[0];
            c    = f[1];
        end
        return {c, s};
    endfunction

`ifdef PIPE_ADDER_SAT_EN
    function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] s,
                                                 input logic             ovf,
                                                 input logic             a_msb);
        if (!ovf)
            return s;
        return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    logic w_stall;
    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int LO = k * SEG_W;
        localparam int HI = (k + 1) * SEG_W;

        logic [WIDTH-LO-1:0] w_a_rem;
        logic [WIDTH-LO-1:0] w_b_rem;
        logic                w_ci;
        logic                w_vin;
        logic [SEG_W:0]      w_res;
        logic [HI-1:0]       w_sum_raw;
        logic [HI-1:0]       w_sum_nxt;
        logic                r_vld;
        logic                r_cy;
        logic [HI-1:0]       r_sum;

        // Entry stage conditions B and the carry for subtract; later stages take the skewed operands.
        if (k == 0) begin : g_entry
            assign w_a_rem   = A;
            assign w_b_rem   = B ^ {WIDTH{Sub}};
            assign w_ci      = Cin ^ Sub;
            assign w_vin     = in_valid;
            assign w_sum_raw = w_res[SEG_W-1:0];
        end else begin : g_link
            assign w_a_rem   = g_stg[k-1].g_fwd.r_a_up;
            assign w_b_rem   = g_stg[k-1].g_fwd.r_b_up;
            assign w_ci      = g_stg[k-1].r_cy;
            assign w_vin     = g_stg[k-1].r_vld;
            assign w_sum_raw = {w_res[SEG_W-1:0], g_stg[k-1].r_sum};
        end

        assign w_res = seg_add(w_a_rem[SEG_W-1:0], w_b_rem[SEG_W-1:0], w_ci);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_cy  <= 1'b0;
                r_sum <= '0;
            end else if (!w_stall) begin
                r_vld <= w_vin;
                r_cy  <= w_res[SEG_W];
                r_sum <= w_sum_nxt;
            end
        end

        if (k < NSTG - 1) begin : g_fwd
            logic [WIDTH-HI-1:0] r_a_up;
            logic [WIDTH-HI-1:0] r_b_up;

            assign w_sum_nxt = w_sum_raw;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a_up <= '0;
                    r_b_up <= '0;
                end else if (!w_stall) begin
                    r_a_up <= w_a_rem[WIDTH-LO-1:SEG_W];
                    r_b_up <= w_b_rem[WIDTH-LO-1:SEG_W];
                end
            end
        end else begin : g_last
            logic w_ovf;
            logic r_ovf;

            // Carry into the MSB is recovered from the MSB sum bit: c_in = s ^ a ^ b.
            assign w_ovf = w_res[SEG_W] ^ w_res[SEG_W-1] ^ w_a_rem[SEG_W-1] ^ w_b_rem[SEG_W-1];
`ifdef PIPE_ADDER_SAT_EN
            assign w_sum_nxt = sat_sum(w_sum_raw, w_ovf, w_a_rem[SEG_W-1]);
`else
            assign w_sum_nxt = w_sum_raw;
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_ovf <= 1'b0;
                else if (!w_stall)
                    r_ovf <= w_ovf;
            end
        end
    end

    assign out_valid = g_stg[NSTG-1].r_vld;
    assign Sum       = g_stg[NSTG-1].r_sum;
    assign Cout      = g_stg[NSTG-1].r_cy;
    assign Ovf       = g_stg[NSTG-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder (WIDTH=16, SEG_W=4): vector table, stream, backpressure, reset.
module tb_pipe_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, Cin, Sub;
    logic         out_valid, out_ready, Cout, Ovf;
    logic [W-1:0] A, B, Sum;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum_wrap;
        logic [W-1:0] sum_sat;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t         tbl[10];
    logic [17:0]  sb_q[$];

    pipe_adder #(.WIDTH(16), .SEG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: {ovf, cout, sum}
    function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
        logic [W-1:0] bb;
        logic         ci;
        logic [W:0]   full;
        logic [W-1:0] low;
        logic         ovf;
        logic [W-1:0] s;
        bb   = sub ? ~b : b;
        ci   = sub ? ~cin : cin;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
        low  = {1'b0, a[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, ci};
        ovf  = low[W-1] ^ full[W];
        s    = full[W-1:0];
`ifdef PIPE_ADDER_SAT_EN
        if (ovf) s = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return {ovf, full[W], s};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        in_valid = v;
        A = a;
        B = b;
        Cin = cin;
        Sub = sub;
    endtask

    // One clock: record handshakes into the scoreboard just before the edge, then step.
    task automatic cyc();
        logic [17:0] e;
        #2;
        if (in_valid && in_ready) sb_q.push_back(model(A, B, Cin, Sub));
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("spurious_out", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                n_pop++;
                chk("sb_sum", 32'(Sum), 32'(e[15:0]));
                chk("sb_cout", 32'(Cout), 32'(e[16]));
                chk("sb_ovf", 32'(Ovf), 32'(e[17]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input vec_t v);
        int lat;
        logic [W-1:0] es;
`ifdef PIPE_ADDER_SAT_EN
        es = v.sum_sat;
`else
        es = v.sum_wrap;
`endif
        drive(1'b1, v.a, v.b, v.cin, v.sub);
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        lat = 0;
        while (!out_valid && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency_edges", 32'(lat), 32'd3);
        chk("vec_sum", 32'(Sum), 32'(es));
        chk("vec_cout", 32'(Cout), 32'(v.cout));
        chk("vec_ovf", 32'(Ovf), 32'(v.ovf));
        @(posedge clk);
        #1;
        chk("one_cycle_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] sa[9];
        logic [W-1:0] sbv[9];
        logic         sv[9];
        logic         scin[9];
        int           j, budget;

        //          a         b         cin   sub   wrap      sat       cout  ovf
        tbl[0] = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 16'h2234, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
        tbl[4] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b0};
        tbl[5] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
        tbl[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
        tbl[7] = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
        tbl[8] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[9] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};

        sa   = '{16'h1111, 16'h9000, 16'h00FF, 16'h0000, 16'h7FFF, 16'h0010, 16'hFFF0, 16'h4321, 16'h8001};
        sbv  = '{16'h2222, 16'h1000, 16'h0F01, 16'h0000, 16'h7FFF, 16'h0020, 16'h0010, 16'h1234, 16'h0002};
        sv   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        scin = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(Sum), 32'd0);
        chk("rst_cout", 32'(Cout), 32'd0);
        chk("rst_ovf", 32'(Ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_one(tbl[i]);

        // Stream: 8 beats alternating add/subtract, bubble in slot 3.
        j = 0;
        for (int c = 0; c < 13; c++) begin
            if (c < 9)
                drive(sv[c], sa[c], sbv[c], scin[c], 1'(j % 2));
            else
                drive(1'b0, '0, '0, 1'b0, 1'b0);
            if (c < 9 && sv[c]) j++;
            if (c < 4)
                chk("stream_idle", 32'(out_valid), 32'd0);
            else
                chk("stream_valid", 32'(out_valid), 32'(sv[c-4]));
            cyc();
        end
        chk("stream_drained", 32'(sb_q.size()), 32'd0);

        // Backpressure with a full pipeline.
        n_pop = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 16'h0100 * 16'(c + 1), 16'h00F1, 1'b1, 1'(c % 2));
            cyc();
        end
        out_ready = 1'b0;
        drive(1'b1, 16'h7FF0, 16'h0020, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'(Sum), 32'(sb_q[0][15:0]));
            cyc();
        end
        chk("stall_inflight", 32'(sb_q.size()), 32'd4);
        out_ready = 1'b1;
        cyc();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        budget = 0;
        while (sb_q.size() > 0 && budget < 20) begin
            cyc();
            budget++;
        end
        chk("bp_pops", 32'(n_pop), 32'd5);
        chk("bp_drained", 32'(sb_q.size()), 32'd0);
        chk("bp_idle", 32'(out_valid), 32'd0);

        // Reset with operations in flight and one result presented.
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 16'h0F0F + 16'(c), 16'h1111, 1'b0, 1'b0);
            cyc();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_sum", 32'(Sum), 32'd0);
        chk("async_rst_cout", 32'(Cout), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        sb_q.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("no_stale", 32'(out_valid), 32'd0);
            cyc();
        end
        run_one(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
